data_memory_ctrl: RTL
=====================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised, handshaked data memory for the CPU MEM stage: byte-addressed little-endian word array
//  with byte/half/word loads and stores, sign/zero extension, configurable access latency and error
//  reporting for misaligned or out-of-range accesses. One request in flight; the pipeline stalls on req_ready.
// PARAMETERS
//  ADDR_W       32    byte-address width
//  DEPTH_WORDS  2048  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//  LATENCY      2     cycles from accept edge to response edge for legal accesses; >=1
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous, active-low reset
//  req_valid     in   1       request present
//  req_ready     out  1       controller can accept; transfer on req_valid && req_ready at rising clk
//  req_write     in   1       1 = store, 0 = load
//  req_addr      in   ADDR_W  byte address
//  req_wdata     in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  req_size      in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1       loads: 1 = zero-extend, 0 = sign-extend
//  resp_valid    out  1       one-cycle response pulse; no backpressure
//  resp_rdata    out  32      load result, extended; 0 for stores and errors
//  resp_err      out  1       valid with resp_valid: access rejected
//  busy          out  1       request in flight (state != IDLE)
// BEHAVIOUR
//  - Reset (rst low): state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, req_ready 0.
//    Memory array is not cleared; contents are retained across reset. req_ready = rst && state != BUSY.
//  - States: IDLE, BUSY, RESP. Accept at edge T captures write/addr/wdata/size/unsigned.
//  - Error check at accept: size==11, half with addr[0]!=0, word with addr[1:0]!=0, or
//    addr[ADDR_W-1:2] >= DEPTH_WORDS. Error -> RESP at T+1 regardless of LATENCY: resp_err 1, rdata 0,
//    no array write.
//  - Legal: LATENCY==1 -> RESP at T+1; else BUSY, counter loaded LATENCY-1, decrements each edge,
//    -> RESP when it reaches 1. resp_valid high exactly during cycle after edge T+LATENCY.
//  - Array access happens on the edge entering RESP: store writes only addressed lanes (byte lane
//    addr[1:0], half lanes addr[1]*2..+1, word all); load reads the word, selects lane, extends to 32.
//  - RESP: req_ready 1; new accept in RESP goes straight to BUSY/RESP per rules above (back-to-back,
//    one request per LATENCY cycles); otherwise -> IDLE and resp_valid/err drop to 0.
//  - req_ready 0 in BUSY; req_valid ignored there. Inputs need only be stable at the accept edge.
//  - Reset mid-BUSY: request aborted, no write, no response issued.
//  - Store then load to same address back-to-back returns the stored data (write lands first).
// TESTING
//  1. Reset, store word 0xDEADBEEF @0x100, load word @0x100 -> resp_valid at accept+2, rdata 0xDEADBEEF, err 0.
//  2. Store byte 0x80 @0x101 over 0x00000000, load byte signed @0x101 -> 0xFFFFFF80; unsigned -> 0x00000080;
//     load word @0x100 -> 0x00008000.
//  3. Load half @0x102 (misaligned? no) then half @0x103 -> second response at accept+1, err 1, rdata 0.
//  4. Word store @4*DEPTH_WORDS -> err 1, then load @0 shows memory unchanged; size 11 -> err 1.
//  5. LATENCY=1 and LATENCY=4 builds: hold req_valid high for 8 requests -> one response every LATENCY
//     cycles, req_ready low exactly during BUSY.
//  6. Assert rst low during BUSY of a store 0x12345678 @0x40 (old 0x0) -> no resp_valid, load @0x40 -> 0x0.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Handshaked little-endian data memory for the MEM stage: byte/half/word loads and stores,
// sign/zero extension, fixed access latency, one request in flight, error response on bad accesses.
module data_memory_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [1:0]      off_q, off_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            req_err;
    logic            do_access;
    logic            mem_we;
    logic            acc_write;
    logic [IdxW-1:0] acc_idx;
    logic [1:0]      acc_off;
    logic [31:0]     acc_wdata;
    logic [1:0]      acc_size;
    logic            acc_uns;
    logic [31:0]     rd_word;
    logic [31:0]     ld_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     st_data;
    logic [3:0]      st_be;

    assign req_ready  = rst && (state_q != StBusy);
    assign accept     = req_valid && req_ready;
    assign busy       = (state_q != StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    assign req_err = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));

    // The access on the edge into RESP uses live inputs when entered straight from an accept,
    // and the captured request when the latency countdown expires.
    always_comb begin
        if (state_q == StBusy) begin
            acc_write = write_q;
            acc_idx   = idx_q;
            acc_off   = off_q;
            acc_wdata = wdata_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
        end else begin
            acc_write = req_write;
            acc_idx   = req_addr[IdxW+1:2];
            acc_off   = req_addr[1:0];
            acc_wdata = req_wdata;
            acc_size  = req_size;
            acc_uns   = req_unsigned;
        end
    end

    always_comb begin
        rd_word = mem[acc_idx];
        ld_byte = rd_word[8*acc_off +: 8];
        ld_half = acc_off[1] ? rd_word[31:16] : rd_word[15:0];
        st_data = acc_wdata;
        st_be   = 4'b1111;
        ld_data = rd_word;
        case (acc_size)
            2'b00: begin
                ld_data = acc_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
                st_data = {4{acc_wdata[7:0]}};
                st_be   = 4'b0001 << acc_off;
            end
            2'b01: begin
                ld_data = acc_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
                st_data = {2{acc_wdata[15:0]}};
                st_be   = acc_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                ld_data = rd_word;
                st_data = acc_wdata;
                st_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        do_access    = 1'b0;
        case (state_q)
            StIdle, StResp: begin
                if (accept) begin
                    write_d = req_write;
                    idx_d   = req_addr[IdxW+1:2];
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (req_err) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (LATENCY <= 1) begin
                        state_d   = StResp;
                        do_access = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntW'(LATENCY - 1);
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (cnt_q == CntW'(1)) begin
                    state_d   = StResp;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        if (do_access) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = acc_write ? 32'h0 : ld_data;
        end
    end

    assign mem_we = do_access && acc_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
        end
    end

endmodule
